// File: rtl/alu_dec_stage.sv
// alu_dec_stage: registered ALU decoder with valid/ready flow control.
// Decodes op/funct into a 5-bit ALU code and holds it in one pipeline slot.
// Ports: clk, resetn (async, active-low); in_valid/in_ready/in_op/in_funct
// upstream; flush squash; out_valid/out_ready/out_alucontrol/out_hilo/
// out_illegal downstream; md_busy = HI/LO busy counter non-zero.
// Optional macro ALUDEC_ILLEGAL_EN: flag unrecognised encodings on out_illegal.
module alu_dec_stage #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W =
      $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] in_op,
   input  logic [5:0] in_funct,
   input  logic       flush,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] out_alucontrol,
   output logic       out_hilo,
   output logic       out_illegal,
   output logic       md_busy
);

   localparam logic [4:0] ALU_DONOTHING = 5'd0;
   localparam logic [4:0] ALU_AND   = 5'd1;
   localparam logic [4:0] ALU_OR    = 5'd2;
   localparam logic [4:0] ALU_XOR   = 5'd3;
   localparam logic [4:0] ALU_NOR   = 5'd4;
   localparam logic [4:0] ALU_SLL   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_SLLV  = 5'd8;
   localparam logic [4:0] ALU_SRLV  = 5'd9;
   localparam logic [4:0] ALU_SRAV  = 5'd10;
   localparam logic [4:0] ALU_MFHI  = 5'd11;
   localparam logic [4:0] ALU_MFLO  = 5'd12;
   localparam logic [4:0] ALU_MTHI  = 5'd13;
   localparam logic [4:0] ALU_MTLO  = 5'd14;
   localparam logic [4:0] ALU_ADD   = 5'd15;
   localparam logic [4:0] ALU_ADDU  = 5'd16;
   localparam logic [4:0] ALU_SUB   = 5'd17;
   localparam logic [4:0] ALU_SUBU  = 5'd18;
   localparam logic [4:0] ALU_SLT   = 5'd19;
   localparam logic [4:0] ALU_SLTU  = 5'd20;
   localparam logic [4:0] ALU_DIV   = 5'd21;
   localparam logic [4:0] ALU_DIVU  = 5'd22;
   localparam logic [4:0] ALU_MULT  = 5'd23;
   localparam logic [4:0] ALU_MULTU = 5'd24;
   localparam logic [4:0] ALU_LUI   = 5'd25;

   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

   logic [4:0]       w_code;
   logic             w_hilo;
   logic             w_mul;
   logic             w_div;
   logic             w_stall;
   logic             w_accept;
   logic             r_valid;
   logic [4:0]       r_code;
   logic             r_hilo;
   logic [CNT_W-1:0] r_cnt;

   always_comb begin
      w_code = ALU_DONOTHING;
      if (in_op == 6'b000000) begin
         case (in_funct)
            6'b000000: w_code = ALU_SLL;
            6'b000010: w_code = ALU_SRL;
            6'b000011: w_code = ALU_SRA;
            6'b000100: w_code = ALU_SLLV;
            6'b000110: w_code = ALU_SRLV;
            6'b000111: w_code = ALU_SRAV;
            6'b010000: w_code = ALU_MFHI;
            6'b010001: w_code = ALU_MTHI;
            6'b010010: w_code = ALU_MFLO;
            6'b010011: w_code = ALU_MTLO;
            6'b011000: w_code = ALU_MULT;
            6'b011001: w_code = ALU_MULTU;
            6'b011010: w_code = ALU_DIV;
            6'b011011: w_code = ALU_DIVU;
            6'b100000: w_code = ALU_ADD;
            6'b100001: w_code = ALU_ADDU;
            6'b100010: w_code = ALU_SUB;
            6'b100011: w_code = ALU_SUBU;
            6'b100100: w_code = ALU_AND;
            6'b100101: w_code = ALU_OR;
            6'b100110: w_code = ALU_XOR;
            6'b100111: w_code = ALU_NOR;
            6'b101010: w_code = ALU_SLT;
            6'b101011: w_code = ALU_SLTU;
            default:   w_code = ALU_DONOTHING;
         endcase
      end else begin
         case (in_op)
            6'b001000: w_code = ALU_ADD;
            6'b001001: w_code = ALU_ADDU;
            6'b001010: w_code = ALU_SLT;
            6'b001011: w_code = ALU_SLTU;
            6'b001100: w_code = ALU_AND;
            6'b001101: w_code = ALU_OR;
            6'b001110: w_code = ALU_XOR;
            6'b001111: w_code = ALU_LUI;
            default:   w_code = ALU_DONOTHING;
         endcase
      end
   end

   assign w_mul  = (w_code == ALU_MULT) || (w_code == ALU_MULTU);
   assign w_div  = (w_code == ALU_DIV)  || (w_code == ALU_DIVU);
   assign w_hilo = w_mul || w_div ||
                   (w_code == ALU_MFHI) || (w_code == ALU_MFLO) ||
                   (w_code == ALU_MTHI) || (w_code == ALU_MTLO);

   assign md_busy  = (r_cnt != '0);
   // A MULT/DIV arriving while busy is also stalled, so a running
   // counter is never reloaded.
   assign w_stall  = w_hilo && md_busy;
   assign in_ready = resetn && !flush && !w_stall &&
                     (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_code  <= ALU_DONOTHING;
         r_hilo  <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_code  <= w_code;
         r_hilo  <= w_hilo;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (flush) begin
         r_cnt <= '0;
      end else if (w_accept && w_mul) begin
         r_cnt <= MUL_LD;
      end else if (w_accept && w_div) begin
         r_cnt <= DIV_LD;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

`ifdef ALUDEC_ILLEGAL_EN
   logic w_unknown;
   logic r_illegal;

   // Every recognised encoding maps to a code other than DONOTHING.
   assign w_unknown = (w_code == ALU_DONOTHING);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_illegal <= 1'b0;
      end else if (!flush && w_accept) begin
         r_illegal <= w_unknown;
      end
   end

   assign out_illegal = r_illegal;
`else
   assign out_illegal = 1'b0;
`endif

   assign out_valid      = r_valid;
   assign out_alucontrol = r_code;
   assign out_hilo       = r_hilo;

endmodule

// File: doc/alu_dec_stage.md
# alu_dec_stage

Registered, handshaked successor to the combinational ALU decoder. It decodes `op`/`funct` into the 5-bit ALU control code and holds the result in a single-entry pipeline register with valid/ready flow control. It tracks the latency of multi-cycle MULT/DIV operations and stalls any later HI/LO-touching instruction until that latency expires. It sits between the ID-stage instruction register and the EX-stage ALU/mul-div unit.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: cycles HI/LO is busy after a MULT/MULTU is accepted; must be ≥1.
- `DIV_CYCLES`, default 32: cycles HI/LO is busy after a DIV/DIVU is accepted; must be ≥1.
- `CNT_W`, default `$clog2(max(MUL_CYCLES,DIV_CYCLES)+1)`: busy-counter width; derived, do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_op`  in  6  instruction[31:26].
- `in_funct`  in  6  instruction[5:0].
- `flush`  in  1  synchronous squash of the stage.
- `out_valid`  out  1  registered entry valid.
- `out_ready`  in  1  EX consumes the entry this cycle.
- `out_alucontrol`  out  5  `ALU_*` code from `aludefines.vh`.
- `out_hilo`  out  1  entry reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU).
- `out_illegal`  out  1  unrecognised op/funct (see Configuration).
- `md_busy`  out  1  busy counter non-zero.

## Operation
- Decode map, R-type (op 000000):
  - AND/OR/XOR/NOR map to `ALU_AND`/`ALU_OR`/`ALU_XOR`/`ALU_NOR`.
  - SLL/SRL/SRA/SLLV/SRLV/SRAV map to the matching shift codes.
  - MFHI/MFLO/MTHI/MTLO map to the matching HI/LO codes.
  - ADD/ADDU/SUB/SUBU/SLT/SLTU map to the matching arithmetic and compare codes.
  - DIV/DIVU/MULT/MULTU map to the matching mul-div codes.
- Decode map, immediate forms:
  - ANDI→`ALU_AND`, ORI→`ALU_OR`, XORI→`ALU_XOR`, LUI→`ALU_LUI`.
  - ADDI→`ALU_ADD`, ADDIU→`ALU_ADDU`, SLTI→`ALU_SLT`, SLTIU→`ALU_SLTU`.
- Any other op, or an unlisted R-type funct, gives `ALU_DONOTHING`. The decoder is fully combinational before the register and has no latches.
- Stall and accept:
  - `hilo_in` = decoded instruction touches HI/LO.
  - `stall` = `hilo_in && md_busy`.
  - `in_ready` = `resetn && !flush && !stall && (!out_valid || out_ready)`.
  - Accept = `in_valid && in_ready`. On accept, the register loads the decoded code, `out_hilo` and `out_illegal`, and sets `out_valid`.
- Output register update:
  - If `out_valid && out_ready` with no accept, `out_valid` clears.
  - Register contents are held stable while `out_valid && !out_ready`.
- Busy counter:
  - On accept of MULT/MULTU the counter loads `MUL_CYCLES`. On accept of DIV/DIVU it loads `DIV_CYCLES`.
  - Otherwise the counter decrements by 1 per cycle while non-zero and saturates at 0.
  - Non-HI/LO instructions are never stalled by the counter.
- Flush: synchronous. It clears `out_valid` and the counter to 0, and it wins over accept and consume in the same cycle.

## Timing
- Reset values:
  - `out_valid`=0, `out_alucontrol`=`ALU_DONOTHING`, `out_hilo`=0, `out_illegal`=0.
  - Counter=0, so `md_busy`=0.
  - `in_ready`=0 while `resetn` is low.
- Latency: an instruction accepted at edge t is visible on the outputs at t+1 (one cycle).
- Full throughput: back-to-back accepts are allowed whenever `out_ready`=1. A consume and an accept in the same cycle are legal (entry replaced).
- MUL timing for a MULT accepted at edge t:
  - `md_busy` is high for exactly `MUL_CYCLES` cycles after t.
  - A following MFLO can be accepted at edge t+`MUL_CYCLES`+1 at the earliest, given out_ready=1.
  - The same rule applies with `DIV_CYCLES` for DIV.
- A MULT arriving while busy is itself stalled; it never reloads a running counter.
- Reset asserted mid-operation aborts immediately: all state returns to reset values asynchronously.

## Configuration
- Macro `ALUDEC_ILLEGAL_EN`.
- Defined: an unrecognised op/funct sets `out_illegal`=1 with `ALU_DONOTHING`. The entry still passes through the register so the exception unit can trap it.
- Undefined: `out_illegal` is tied to 0, and unrecognised encodings silently produce `ALU_DONOTHING`.

## Test plan
- Reset with `in_valid`=1 and ADD presented (op 000000, funct 100000):
  - All outputs hold reset values and `in_ready`=0.
  - After `resetn` rises, one cycle later `out_alucontrol`=`ALU_ADD`, `out_valid`=1.
- Backpressure: accept ORI (001101), hold `out_ready`=0 for 3 cycles while presenting ANDI:
  - `in_ready`=0 and `out_alucontrol` stays `ALU_OR`.
  - On `out_ready`=1, ANDI loads the next cycle.
- MUL/DIV stall, `MUL_CYCLES`=4: MULT (funct 011000), then MFLO (010010), then ADDU (100001):
  - MFLO is stalled for 4 cycles and ADDU behind it waits.
  - Repeat with DIV (011010) and `DIV_CYCLES`=32: 32 stall cycles.
- Non-HI/LO pass-through: DIV accepted, then SLT (101010):
  - SLT accepted the next cycle while `md_busy`=1.
- Flush: flush in the same cycle as a valid MFHI accept while busy:
  - `out_valid`=0 and `md_busy`=0 next cycle.
  - MFHI is accepted the cycle after flush deasserts.
- Illegal: op 111111 presented.
  - With `ALUDEC_ILLEGAL_EN`: `out_illegal`=1, `ALU_DONOTHING`.
  - Without: `out_illegal`=0.
